// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    localparam int unsigned MaxDataBits = 9;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [MaxDataBits-1:0] data, input parity_e mode);
        logic w_bit;
        case (mode)
            PAR_EVEN: w_bit = ^data;
            PAR_ODD:  w_bit = ~(^data);
            default:  w_bit = 1'b0;
        endcase
        return w_bit;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-array FIFO; dout presents the head entry whenever empty is low.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     QUICK_CLOCK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PtrOne    = AW'(1);
    localparam logic [AW:0]   CountOne  = (AW+1)'(1);
    localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == FullCount);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge QUICK_CLOCK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CountOne;
                2'b01:   r_count <= r_count - CountOne;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge QUICK_CLOCK) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered async serial transmitter: handshake into a FIFO, one frame per queued word,
// back-to-back frames when more words are waiting.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 32'h28B0,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          QUICK_CLOCK,
    input  logic                          RESET,
    input  logic [DATA_BITS-1:0]          DATA,
    input  logic                          VALID,
    output logic                          READY,
    output logic                          UART_TX,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [31:0]   BaudLast = 32'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DataLast = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BitOne   = BW'(1);
    localparam parity_e       ParMode  = parity_e'(2'(PARITY));

    state_e               r_state, w_state_next;
    logic [31:0]          r_baud, w_baud_next;
    logic [BW-1:0]        r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_par, w_par_next;
    logic                 r_tx, w_tx_next;
    logic                 w_baud_end;
    logic                 w_load;
    logic                 w_push;
    logic [DATA_BITS-1:0] w_dout;
    logic                 w_full;
    logic                 w_empty;

    assign READY   = !w_full;
    assign w_push  = VALID && READY;
    assign UART_TX = r_tx;
    assign BUSY    = (r_state != StIdle) || (FIFO_COUNT != '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .QUICK_CLOCK (QUICK_CLOCK),
        .RESET       (RESET),
        .push        (w_push),
        .pop         (w_load),
        .din         (DATA),
        .dout        (w_dout),
        .count       (FIFO_COUNT),
        .full        (w_full),
        .empty       (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = '0;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_tx_next    = r_tx;
        w_load       = 1'b0;
        w_baud_end   = (r_baud == BaudLast);

        if (r_state != StIdle) w_baud_next = w_baud_end ? '0 : r_baud + 32'd1;

        unique case (r_state)
            StIdle: begin
                w_tx_next = 1'b1;
                w_load    = !w_empty;
            end
            StStart: begin
                if (w_baud_end) begin
                    w_tx_next    = r_shift[0];
                    w_shift_next = r_shift >> 1;
                    w_bit_next   = '0;
                    w_state_next = StData;
                end
            end
            StData: begin
                if (w_baud_end) begin
                    if (r_bit == DataLast) begin
                        w_bit_next = '0;
                        if (ParMode != PAR_NONE) begin
                            w_tx_next    = r_par;
                            w_state_next = StParity;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = StStop;
                        end
                    end else begin
                        w_tx_next    = r_shift[0];
                        w_shift_next = r_shift >> 1;
                        w_bit_next   = r_bit + BitOne;
                    end
                end
            end
            StParity: begin
                if (w_baud_end) begin
                    w_tx_next    = 1'b1;
                    w_bit_next   = '0;
                    w_state_next = StStop;
                end
            end
            StStop: begin
                if (w_baud_end) begin
                    if (r_bit == StopLast) begin
                        w_tx_next    = 1'b1;
                        w_state_next = StIdle;
                        w_load       = !w_empty;
                    end else begin
                        w_bit_next = r_bit + BitOne;
                    end
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_state_next = StIdle;
            end
        endcase

        // Popping a word starts the start bit on the next edge, from idle or straight out of stop.
        if (w_load) begin
            w_shift_next = w_dout;
            w_par_next   = parity_bit(MaxDataBits'(w_dout), ParMode);
            w_tx_next    = 1'b0;
            w_bit_next   = '0;
            w_baud_next  = '0;
            w_state_next = StStart;
        end
    end

    always_ff @(posedge QUICK_CLOCK) begin
        if (RESET) begin
            r_state <= StIdle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
            r_tx    <= w_tx_next;
        end
    end

endmodule
